print_line_sequencer: RTL and testbench
=======================================

PRINT_LINE_SEQUENCER -- requirements
Module: print_line_sequencer

Interface
REQ-001 Parameters SHALL be: BYTES_PER_LINE, default 32, bytes per printed line (256 dots); SCLK_HALF, default 5, CLK cycles per CLKimpr half-period; LAT_CYCLES, default 4, LAT pulse width; STB_CYCLES, default 50000, STB burn width (1 ms at 50 MHz).
REQ-002 Ports SHALL be:
CLK  in  1  system clock, 50 MHz, rising edge.
RST_N  in  1  asynchronous, active-low reset.
rx_valid  in  1  one-cycle pulse, byte available from UART receiver.
rx_data  in  8  received byte.
DO  out  1  serial dot data to print head.
CLKimpr  out  1  head shift clock.
LAT  out  1  head latch pulse.
STB  out  1  head strobe (heater enable).
step_req  out  1  request one paper-feed line step from motor driver.
step_done  in  1  one-cycle pulse, motor step finished.
busy  out  1  high whenever FSM is not IDLE.
line_cnt  out  8  lines completed, wraps 255->0.
overrun  out  1  sticky, byte dropped because both banks full.

Function
REQ-003 Block SHALL hold two line banks (A, B) of BYTES_PER_LINE bytes each; the fill bank and the print bank SHALL be distinct.
REQ-004 Each rx_valid SHALL write rx_data to the fill bank at the fill pointer and increment it; on reaching BYTES_PER_LINE the bank SHALL be marked full and filling SHALL switch to the other bank if it is empty.
REQ-005 rx_valid while both banks are full SHALL drop the byte and set overrun, which is cleared only by reset.
REQ-006 FSM states SHALL be IDLE, SHIFT, LATCH, STROBE, STEP; IDLE->SHIFT in the cycle after any bank becomes full, the oldest full bank being selected (A on tie).
REQ-007 SHIFT SHALL send byte 0 first, MSB first: DO updates while CLKimpr is low, then CLKimpr high for SCLK_HALF cycles and low for SCLK_HALF cycles per bit, 8*BYTES_PER_LINE bits total.
REQ-008 After the last CLKimpr falling edge, LATCH SHALL drive LAT high for exactly LAT_CYCLES cycles with CLKimpr low.
REQ-009 STROBE SHALL then drive STB high for exactly STB_CYCLES cycles; STB SHALL never be high outside STROBE.
REQ-010 STEP SHALL raise step_req and hold it until step_done; in the step_done cycle step_req SHALL drop, the print bank SHALL be freed and line_cnt SHALL increment.
REQ-011 From STEP, the FSM SHALL go to SHIFT if the other bank is full, else to IDLE.
REQ-012 step_done outside STEP SHALL be ignored.
REQ-013 A byte arriving in the same cycle a bank is freed SHALL be accepted into the freed bank if the other bank is full (no overrun).
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 RST_N low SHALL asynchronously force IDLE, both banks empty, fill bank A, fill pointer 0, and DO, CLKimpr, LAT, STB, step_req, busy, overrun = 0, line_cnt = 0.
REQ-016 Reset asserted mid-line SHALL drop STB and step_req immediately; the partial line SHALL be discarded.

Configuration
REQ-017 With SEQ_BLANK_SKIP_EN defined, a full bank whose bytes are all 0x00 SHALL go IDLE/STEP directly to STEP, skipping SHIFT, LATCH, STROBE (no CLKimpr, LAT or STB activity); without it, blank lines SHALL be shifted, latched and strobed like any other line.

Verification
REQ-018 32 bytes 0xA5 at 9600 baud -> DO pattern 1010_0101 repeated 32 times on CLKimpr rising edges, 256 CLKimpr pulses, then LAT high 4 cycles, STB high 50000 cycles, step_req until step_done, line_cnt=1.
REQ-019 7 back-to-back lines of 32 bytes 0xFF -> 7 SHIFT/LATCH/STROBE/STEP sequences, line_cnt=7, overrun=0, busy low at end.
REQ-020 step_done withheld, 64 further bytes sent -> first 32 fill the free bank, byte 33 onward sets overrun=1, line data unaffected.
REQ-021 RST_N low during STROBE -> STB, step_req, LAT, CLKimpr = 0 within same cycle, line_cnt=0, banks empty; new line afterwards prints normally.
REQ-022 32 bytes 0x00 with SEQ_BLANK_SKIP_EN -> no CLKimpr/LAT/STB edges, step_req asserted, line_cnt=1; without macro -> 256 CLKimpr pulses, DO=0 throughout, LAT and STB pulses present.

Source files
------------

// File: rtl/print_line_sequencer.sv
// print_line_sequencer: double-buffered thermal print-head line sequencer.
// Bytes from a UART receiver fill two line banks (A, B) in turn; each full
// bank is shifted MSB-first to the head, latched, strobed, then a paper-feed
// step is requested before the bank is freed.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   rx_valid, rx_data     one-cycle byte strobe and data from the UART
//   DO, CLKimpr           head serial dot data and shift clock
//   LAT, STB              head latch pulse and strobe (heater enable)
//   step_req, step_done   paper-feed handshake with the motor driver
//   busy                  sequencer not IDLE
//   line_cnt              completed lines, wraps 255->0
//   overrun               sticky, byte dropped with both banks full
// Optional: define SEQ_BLANK_SKIP_EN to go straight to STEP for all-zero lines.
module print_line_sequencer #(
   parameter int BYTES_PER_LINE = 32,
   parameter int SCLK_HALF      = 5,
   parameter int LAT_CYCLES     = 4,
   parameter int STB_CYCLES     = 50000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       DO,
   output logic       CLKimpr,
   output logic       LAT,
   output logic       STB,
   output logic       step_req,
   input  logic       step_done,
   output logic       busy,
   output logic [7:0] line_cnt,
   output logic       overrun
);
   localparam int PW = $clog2(BYTES_PER_LINE);
   localparam int BW = $clog2(8 * BYTES_PER_LINE);
   typedef enum logic [2:0] {IDLE, SHIFT, LATCH, STROBE, STEP} state_t;
   state_t        state_q;
   logic          pb_q, fill_q, fill_d, wbank, free, stuck, accept, sel;
   logic          blank_sel, blank_oth;
   logic [1:0]    full_q, full_d;
   logic [PW-1:0] ptr_q, ptr_d, wptr;
   logic [BW-1:0] bit_q, nbit;
   logic [31:0]   cnt_q;
   logic [7:0]    lcnt_q;
   logic          do_q, sclk_q, lat_q, stb_q, req_q, busy_q, ovr_q;
   logic [7:0]    mem_q [2][BYTES_PER_LINE];
   assign {DO, CLKimpr, LAT, STB, step_req, busy, overrun} = {do_q, sclk_q, lat_q, stb_q, req_q, busy_q, ovr_q};
   assign line_cnt = lcnt_q;
   assign free = (state_q == STEP) && step_done;
   // The fill bank only stays on a full bank when both are full; a bank freed
   // this very cycle takes the incoming byte instead of dropping it.
   assign stuck  = full_q[fill_q] && !free;
   assign wbank  = (free && full_q[fill_q]) ? pb_q : fill_q;
   assign wptr   = (free && full_q[fill_q]) ? '0 : ptr_q;
   assign accept = rx_valid && !stuck;
   assign sel    = ~full_q[0];
   assign nbit   = bit_q + BW'(1);
   always_comb begin
      full_d = full_q;
      fill_d = wbank;
      ptr_d  = wptr;
      if (free) full_d[pb_q] = 1'b0;
      if (accept) begin
         ptr_d = wptr + PW'(1);
         if (wptr == PW'(BYTES_PER_LINE - 1)) begin
            full_d[wbank] = 1'b1;
            ptr_d         = '0;
            fill_d        = full_d[~wbank] ? wbank : ~wbank;
         end
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         full_q <= '0;
         fill_q <= 1'b0;
         ptr_q  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         fill_q <= fill_d;
         ptr_q  <= ptr_d;
         ovr_q  <= ovr_q | (rx_valid && stuck);
      end
   end
   always_ff @(posedge CLK) begin
      if (accept) mem_q[wbank][wptr] <= rx_data;
   end
`ifdef SEQ_BLANK_SKIP_EN
   // Per-bank "has a non-zero byte" flag, restarted by the first byte of a line.
   logic [1:0] nz_q;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) nz_q <= '0;
      else if (accept) nz_q[wbank] <= (wptr == '0 ? 1'b0 : nz_q[wbank]) | (|rx_data);
   end
   assign blank_sel = !nz_q[sel];
   assign blank_oth = !nz_q[~pb_q];
`else
   assign blank_sel = 1'b0;
   assign blank_oth = 1'b0;
`endif
   // Bit period: CLKimpr high at cnt 0..SCLK_HALF-1, low for the rest;
   // DO advances on the last low cycle so it is settled before the next rise.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pb_q    <= 1'b0;
         bit_q   <= '0;
         cnt_q   <= '0;
         lcnt_q  <= '0;
         {do_q, sclk_q, lat_q, stb_q, req_q, busy_q} <= '0;
      end else begin
         case (state_q)
            IDLE: if (|full_q) begin
               pb_q   <= sel;
               busy_q <= 1'b1;
               cnt_q  <= '0;
               bit_q  <= '0;
               if (blank_sel) begin
                  state_q <= STEP;
                  req_q   <= 1'b1;
               end else begin
                  state_q <= SHIFT;
                  do_q    <= mem_q[sel][0][7];
               end
            end
            SHIFT: begin
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q == '0) sclk_q <= 1'b1;
               if (cnt_q == 32'(SCLK_HALF)) sclk_q <= 1'b0;
               if (cnt_q == 32'(2 * SCLK_HALF - 1)) begin
                  cnt_q <= '0;
                  if (bit_q == BW'(8 * BYTES_PER_LINE - 1)) begin
                     state_q <= LATCH;
                     lat_q   <= 1'b1;
                     do_q    <= 1'b0;
                  end else begin
                     bit_q <= nbit;
                     do_q  <= mem_q[pb_q][nbit[BW-1:3]][~nbit[2:0]];
                  end
               end
            end
            LATCH: begin
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q == 32'(LAT_CYCLES - 1)) begin
                  state_q <= STROBE;
                  lat_q   <= 1'b0;
                  stb_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            STROBE: begin
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q == 32'(STB_CYCLES - 1)) begin
                  state_q <= STEP;
                  stb_q   <= 1'b0;
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            STEP: if (step_done) begin
               req_q  <= 1'b0;
               lcnt_q <= lcnt_q + 8'd1;
               cnt_q  <= '0;
               bit_q  <= '0;
               // A blank waiting bank re-enters through IDLE so step_req drops between steps.
               if (full_q[~pb_q] && !blank_oth) begin
                  state_q <= SHIFT;
                  pb_q    <= ~pb_q;
                  do_q    <= mem_q[~pb_q][0][7];
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_print_line_sequencer.sv
// tb_print_line_sequencer: directed checks of line shifting, latch/strobe timing, bank handoff, overrun and reset.
module tb_print_line_sequencer;
   localparam int BPL = 4, SH = 2, LATC = 4, STBC = 20, NB = 8 * BPL;
   logic CLK = 0, RST_N = 0, rx_valid = 0, man_sd = 0, auto_sd = 0, hold_step = 0;
   logic [7:0] rx_data = 0;
   logic step_done, DO, CLKimpr, LAT, STB, step_req, busy, overrun;
   logic [7:0] line_cnt;
   int checks = 0, errors = 0;
   assign step_done = man_sd | auto_sd;
   always #5 CLK = ~CLK;
   print_line_sequencer #(.BYTES_PER_LINE(BPL), .SCLK_HALF(SH), .LAT_CYCLES(LATC), .STB_CYCLES(STBC)) dut (
      .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_data(rx_data), .DO(DO), .CLKimpr(CLKimpr),
      .LAT(LAT), .STB(STB), .step_req(step_req), .step_done(step_done), .busy(busy),
      .line_cnt(line_cnt), .overrun(overrun));
   int nl = 0, nbits = 0, lat_n = 0, stb_n = 0, hi_n = 0, clk_bad = 0, do_bad = 0, ovl_bad = 0, rises = 0;
   logic clk_p = 0, do_p = 0, lat_p = 0, stb_p = 0;
   logic [NB-1:0] got = 0;
   logic [NB-1:0] line_got [64];
   int line_nb [64], lat_w [64], stb_w [64];
   always @(negedge CLK) begin
      if (!RST_N) begin
         nbits = 0; lat_n = 0; stb_n = 0; hi_n = 0;
         clk_p = 0; lat_p = 0; stb_p = 0;
      end else begin
         if (CLKimpr && !clk_p) begin got = {got[NB-2:0], DO}; nbits++; rises++; end
         if (CLKimpr) hi_n++;
         if (!CLKimpr && clk_p) begin if (hi_n != SH) clk_bad++; hi_n = 0; end
         if (CLKimpr && clk_p && DO != do_p) do_bad++;
         if ((STB && (LAT || CLKimpr)) || (LAT && CLKimpr)) ovl_bad++;
         if (LAT) lat_n++;
         if (LAT && !lat_p && nl < 64) begin
            line_got[nl] = got; line_nb[nl] = nbits; lat_w[nl] = 0; stb_w[nl] = 0; nbits = 0; nl++;
         end
         if (!LAT && lat_p && nl > 0) begin lat_w[nl-1] = lat_n; lat_n = 0; end
         if (STB) stb_n++;
         if (!STB && stb_p && nl > 0) begin stb_w[nl-1] = stb_n; stb_n = 0; end
         clk_p = CLKimpr; do_p = DO; lat_p = LAT; stb_p = STB;
      end
   end
   // Motor driver model: answers step_req after five cycles unless held off.
   int sd_wait = 0;
   always @(negedge CLK) begin
      auto_sd = 0;
      if (step_req && !hold_step) begin
         sd_wait++;
         if (sd_wait == 5) begin auto_sd = 1; sd_wait = 0; end
      end else sd_wait = 0;
   end
   task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, g, e);
      end
   endtask
   task automatic send(input logic [7:0] b);
      @(negedge CLK); rx_valid = 1; rx_data = b;
      @(negedge CLK); rx_valid = 0;
      repeat (48) @(negedge CLK);
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin @(negedge CLK); n++; end
      chk("idle_timeout", busy, 0);
   endtask
   task automatic wait_hi(input logic use_stb, input string nm);
      int n = 0;
      while (!(use_stb ? STB : step_req) && n < 3000) begin @(negedge CLK); n++; end
      chk(nm, use_stb ? STB : step_req, 1);
   endtask
   task automatic check_line(input int idx, input logic [NB-1:0] e);
      chk("line_bits", line_nb[idx], NB);
      chk("line_data", line_got[idx], e);
      chk("lat_width", lat_w[idx], LATC);
      chk("stb_width", stb_w[idx], STBC);
   endtask
   typedef struct { logic [7:0] val; logic inc; int lines; logic [7:0] exp_lc; } vec_t;
   vec_t vt [5];
   initial begin
      int base, r0;
      logic [NB-1:0] e;
      vt[0] = '{8'hA5, 1'b0, 1, 8'd1};
      vt[1] = '{8'hFF, 1'b0, 7, 8'd8};
      vt[2] = '{8'h00, 1'b0, 1, 8'd9};
      vt[3] = '{8'h01, 1'b1, 1, 8'd10};
      vt[4] = '{8'h3C, 1'b0, 2, 8'd12};
      repeat (2) @(negedge CLK);
      chk("rst_DO", DO, 0); chk("rst_CLKimpr", CLKimpr, 0); chk("rst_LAT", LAT, 0); chk("rst_STB", STB, 0);
      chk("rst_step_req", step_req, 0); chk("rst_busy", busy, 0); chk("rst_line_cnt", line_cnt, 0); chk("rst_overrun", overrun, 0);
      RST_N = 1;
      repeat (2) @(negedge CLK);
      for (int v = 0; v < 5; v++) begin
         base = nl; r0 = rises;
         for (int l = 0; l < vt[v].lines; l++)
            for (int i = 0; i < BPL; i++) send(vt[v].inc ? vt[v].val + 8'(i) : vt[v].val);
         wait_idle();
         e = '0;
         for (int i = 0; i < BPL; i++) e = {e[NB-9:0], vt[v].inc ? vt[v].val + 8'(i) : vt[v].val};
         for (int l = 0; l < vt[v].lines; l++) check_line(base + l, e);
         chk("line_cnt", line_cnt, vt[v].exp_lc);
         chk("overrun", overrun, 0);
         chk("busy_end", busy, 0);
         chk("clk_pulses", rises - r0, vt[v].lines * NB);
      end
      // step_done while idle must not count a line
      @(negedge CLK); man_sd = 1;
      @(negedge CLK); man_sd = 0;
      repeat (3) @(negedge CLK);
      chk("stray_step_done", line_cnt, 12);
      chk("stray_busy", busy, 0);
      // withheld step_done: fill second bank, byte on the freeing cycle, then overrun
      hold_step = 1; base = nl;
      for (int i = 0; i < BPL; i++) send(8'h11);
      for (int i = 0; i < BPL; i++) send(8'h22);
      wait_hi(1'b0, "step_req_wait_a");
      chk("both_full_overrun", overrun, 0);
      chk("both_full_busy", busy, 1);
      @(negedge CLK); rx_valid = 1; rx_data = 8'h33; man_sd = 1;
      @(negedge CLK); rx_valid = 0; man_sd = 0;
      chk("free_line_cnt", line_cnt, 13);
      chk("free_accept_overrun", overrun, 0);
      for (int i = 1; i < BPL; i++) send(8'h33 + 8'(i));
      wait_hi(1'b0, "step_req_wait_b");
      send(8'h77);
      chk("overrun_set", overrun, 1);
      chk("held_line_cnt", line_cnt, 13);
      hold_step = 0;
      wait_idle();
      check_line(base, {4{8'h11}});
      check_line(base + 1, {4{8'h22}});
      check_line(base + 2, 32'h33343536);
      chk("after_ovr_line_cnt", line_cnt, 15);
      chk("overrun_sticky", overrun, 1);
      // reset in the middle of the strobe
      for (int i = 0; i < BPL; i++) send(8'h5A);
      wait_hi(1'b1, "stb_wait");
      repeat (3) @(negedge CLK);
      #2 RST_N = 0;
      #1;
      chk("mid_rst_STB", STB, 0); chk("mid_rst_step_req", step_req, 0); chk("mid_rst_LAT", LAT, 0);
      chk("mid_rst_CLKimpr", CLKimpr, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_line_cnt", line_cnt, 0);
      chk("mid_rst_overrun", overrun, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1;
      repeat (2) @(negedge CLK);
      base = nl;
      for (int i = 0; i < BPL; i++) send(8'hC3);
      wait_idle();
      check_line(base, {4{8'hC3}});
      chk("post_rst_line_cnt", line_cnt, 1);
      chk("post_rst_overrun", overrun, 0);
      chk("sclk_high_width", clk_bad, 0);
      chk("do_stable_high", do_bad, 0);
      chk("lat_stb_clk_overlap", ovl_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
